// File: rtl/apb_fabric_slave_ctrl.sv
// rtl/apb_fabric_slave_ctrl.sv - APB3 fabric bridge with slot decode, access timeout and IRQ aggregation
module apb_fabric_slave_ctrl #(
  parameter int NUM_SLAVES     = 4,
  parameter int SLOT_LSB       = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       FAB_CLK,
  input  logic                       FAB_RESET,
  input  logic                       MSSPSEL,
  input  logic                       MSSPENABLE,
  input  logic                       MSSPWRITE,
  input  logic [19:0]                MSSPADDR,
  input  logic [31:0]                MSSPWDATA,
  output logic [31:0]                MSSPRDATA,
  output logic                       MSSPREADY,
  output logic                       MSSPSLVERR,
  output logic [NUM_SLAVES-1:0]      S_PSEL,
  output logic                       S_PENABLE,
  output logic                       S_PWRITE,
  output logic [SLOT_LSB-1:0]        S_PADDR,
  output logic [31:0]                S_PWDATA,
  input  logic [32*NUM_SLAVES-1:0]   S_PRDATA,
  input  logic [NUM_SLAVES-1:0]      S_PREADY,
  input  logic [NUM_SLAVES-1:0]      S_PSLVERR,
  input  logic [NUM_SLAVES-1:0]      S_IRQ,
  output logic                       FABINT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_LOCAL,
    ST_DONE
  } state_t;

  state_t                  state_q;
  logic [SLOT_LSB-1:0]     paddr_q;
  logic [7:0]              off_q;
  logic [31:0]             wdata_q;
  logic                    write_q;
  logic [2:0]              slot_q;
  logic [NUM_SLAVES-1:0]   psel_q;
  logic                    penable_q;
  logic [31:0]             rdata_q;
  logic                    ready_q;
  logic                    slverr_q;
  logic [7:0]              cnt_q;
  logic [NUM_SLAVES-1:0]   irq_pend_q;
  logic [NUM_SLAVES-1:0]   irq_mask_q;
  logic [3:0]              to_stat_q;
  logic                    fabint_q;

  logic [2:0]              req_slot;
  logic [NUM_SLAVES-1:0]   req_onehot;
  logic [31:0]             sel_rdata;
  logic                    sel_ready;
  logic                    sel_err;
  logic [31:0]             loc_rdata;
  logic [NUM_SLAVES-1:0]   irq_w1c;
  logic [NUM_SLAVES-1:0]   irq_pend_d;
  logic [8:0]              cnt_d;
  logic                    unused_addr_bits;

  // Address bits above the slot field carry no meaning for this bridge.
  assign unused_addr_bits = ^MSSPADDR[19:SLOT_LSB+3];

  assign req_slot = MSSPADDR[SLOT_LSB+2:SLOT_LSB];
  assign cnt_d    = {1'b0, cnt_q} + 9'd1;

  // Decode the requested slot to one-hot and mux the active slave's response.
  always_comb begin
    req_onehot = '0;
    sel_rdata  = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (req_slot == 3'(i)) begin
        req_onehot[i] = 1'b1;
      end
      if (slot_q == 3'(i)) begin
        sel_rdata = S_PRDATA[32*i +: 32];
        sel_ready = S_PREADY[i];
        sel_err   = S_PSLVERR[i];
      end
    end
  end

  // Local register read mux; unknown offsets read as zero.
  always_comb begin
    loc_rdata = '0;
    case (off_q)
      8'h00:   loc_rdata[NUM_SLAVES-1:0] = irq_pend_q;
      8'h04:   loc_rdata[NUM_SLAVES-1:0] = irq_mask_q;
      8'h08:   loc_rdata[3:0]            = to_stat_q;
      default: loc_rdata = '0;
    endcase
  end

  // Incoming IRQ levels are OR-ed in after the clear, so a coincident set wins.
  assign irq_w1c    = (state_q == ST_LOCAL && write_q && off_q == 8'h00) ?
                      wdata_q[NUM_SLAVES-1:0] : '0;
  assign irq_pend_d = (irq_pend_q & ~irq_w1c) | S_IRQ;

  // Transfer sequencer, local registers and interrupt aggregation with registered outputs.
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      state_q    <= ST_IDLE;
      paddr_q    <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      slot_q     <= '0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      slverr_q   <= 1'b0;
      cnt_q      <= '0;
      irq_pend_q <= '0;
      irq_mask_q <= '0;
      to_stat_q  <= '0;
      fabint_q   <= 1'b0;
    end else begin
      irq_pend_q <= irq_pend_d;
      fabint_q   <= |(irq_pend_q & irq_mask_q);
      ready_q    <= 1'b0;
      slverr_q   <= 1'b0;
      rdata_q    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (MSSPSEL && !MSSPENABLE) begin
            paddr_q <= MSSPADDR[SLOT_LSB-1:0];
            off_q   <= MSSPADDR[7:0];
            wdata_q <= MSSPWDATA;
            write_q <= MSSPWRITE;
            slot_q  <= req_slot;
            if (req_slot < 3'(NUM_SLAVES)) begin
              psel_q  <= req_onehot;
              state_q <= ST_SETUP;
            end else if (req_slot == 3'd7) begin
              state_q <= ST_LOCAL;
            end else begin
              ready_q  <= 1'b1;
              slverr_q <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          cnt_q <= cnt_d[7:0];
          if (sel_ready) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            ready_q   <= 1'b1;
            slverr_q  <= sel_err;
            rdata_q   <= write_q ? 32'h0 : sel_rdata;
            state_q   <= ST_DONE;
          end else if (cnt_d >= 9'(TIMEOUT_CYCLES)) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            ready_q   <= 1'b1;
            slverr_q  <= 1'b1;
            to_stat_q <= {1'b1, slot_q};
            state_q   <= ST_DONE;
          end
        end
        ST_LOCAL: begin
          if (write_q) begin
            if (off_q == 8'h04) begin
              irq_mask_q <= wdata_q[NUM_SLAVES-1:0];
            end
            if (off_q == 8'h08) begin
              to_stat_q <= '0;
            end
          end
          rdata_q <= write_q ? 32'h0 : loc_rdata;
          ready_q <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign MSSPRDATA  = rdata_q;
  assign MSSPREADY  = ready_q;
  assign MSSPSLVERR = slverr_q;
  assign S_PSEL     = psel_q;
  assign S_PENABLE  = penable_q;
  assign S_PWRITE   = write_q;
  assign S_PADDR    = paddr_q;
  assign S_PWDATA   = wdata_q;
  assign FABINT     = fabint_q;

endmodule

// File: tb/tb_apb_fabric_slave_ctrl.sv
// tb/tb_apb_fabric_slave_ctrl.sv - directed bench for apb_fabric_slave_ctrl
module tb_apb_fabric_slave_ctrl;

  logic         FAB_CLK = 1'b0;
  logic         FAB_RESET;
  logic         MSSPSEL;
  logic         MSSPENABLE;
  logic         MSSPWRITE;
  logic [19:0]  MSSPADDR;
  logic [31:0]  MSSPWDATA;
  logic [31:0]  MSSPRDATA;
  logic         MSSPREADY;
  logic         MSSPSLVERR;
  logic [3:0]   S_PSEL;
  logic         S_PENABLE;
  logic         S_PWRITE;
  logic [7:0]   S_PADDR;
  logic [31:0]  S_PWDATA;
  logic [127:0] S_PRDATA;
  logic [3:0]   S_PREADY;
  logic [3:0]   S_PSLVERR;
  logic [3:0]   S_IRQ;
  logic         FABINT;

  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;

  // Slave behaviour: slot0 never ready, slot1/slot3 zero-wait, slot2 two wait states.
  assign S_PRDATA = {32'hBEEF_0003, 32'h1234_5678, 32'hCAFE_0001, 32'hDEAD_0000};
  assign S_PREADY = {1'b1, (acc_cnt >= 2), 1'b1, 1'b0};

  always #5 FAB_CLK = ~FAB_CLK;

  always @(posedge FAB_CLK) begin
    if (S_PENABLE) acc_cnt <= acc_cnt + 1;
    else           acc_cnt <= 0;
  end

  apb_fabric_slave_ctrl dut (
    .FAB_CLK    (FAB_CLK),
    .FAB_RESET  (FAB_RESET),
    .MSSPSEL    (MSSPSEL),
    .MSSPENABLE (MSSPENABLE),
    .MSSPWRITE  (MSSPWRITE),
    .MSSPADDR   (MSSPADDR),
    .MSSPWDATA  (MSSPWDATA),
    .MSSPRDATA  (MSSPRDATA),
    .MSSPREADY  (MSSPREADY),
    .MSSPSLVERR (MSSPSLVERR),
    .S_PSEL     (S_PSEL),
    .S_PENABLE  (S_PENABLE),
    .S_PWRITE   (S_PWRITE),
    .S_PADDR    (S_PADDR),
    .S_PWDATA   (S_PWDATA),
    .S_PRDATA   (S_PRDATA),
    .S_PREADY   (S_PREADY),
    .S_PSLVERR  (S_PSLVERR),
    .S_IRQ      (S_IRQ),
    .FABINT     (FABINT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives the setup phase, returns at the negedge where MSSPREADY is seen.
  task automatic xfer(input logic wr, input logic [19:0] addr, input logic [31:0] wd,
                      input bit drop, output int lat, output logic [31:0] rd, output logic er,
                      output logic [3:0] ps, output logic [7:0] pa, output logic [31:0] pw,
                      output logic pwr);
    lat = -1; rd = 32'hx; er = 1'bx; ps = 4'hx; pa = 8'hx; pw = 32'hx; pwr = 1'bx;
    MSSPSEL = 1'b1; MSSPENABLE = 1'b0; MSSPWRITE = wr; MSSPADDR = addr; MSSPWDATA = wd;
    for (int k = 1; k <= 400; k++) begin
      @(negedge FAB_CLK);
      if (k == 1) begin
        ps = S_PSEL; pa = S_PADDR; pw = S_PWDATA; pwr = S_PWRITE;
        if (drop) MSSPSEL = 1'b0;
        else      MSSPENABLE = 1'b1;
      end
      if (MSSPREADY) begin
        lat = k; rd = MSSPRDATA; er = MSSPSLVERR;
        break;
      end
    end
    MSSPSEL = 1'b0; MSSPENABLE = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  logic [3:0]  ps;
  logic [7:0]  pa;
  logic [31:0] pw;
  logic        pwr;

  initial begin
    FAB_RESET = 1'b1; MSSPSEL = 1'b0; MSSPENABLE = 1'b0; MSSPWRITE = 1'b0;
    MSSPADDR = '0; MSSPWDATA = '0; S_PSLVERR = '0; S_IRQ = '0;
    repeat (3) @(negedge FAB_CLK);
    chk("rst_ready", 32'(MSSPREADY), 32'h0);
    chk("rst_psel", 32'(S_PSEL), 32'h0);
    chk("rst_penable", 32'(S_PENABLE), 32'h0);
    chk("rst_rdata", MSSPRDATA, 32'h0);
    chk("rst_fabint", 32'(FABINT), 32'h0);
    FAB_RESET = 1'b0;
    @(negedge FAB_CLK);

    // zero-wait write to slot1 offset 0x10
    xfer(1'b1, 20'h00110, 32'hA5A5_0001, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("wr1_psel", 32'(ps), 32'h2);
    chk("wr1_paddr", 32'(pa), 32'h10);
    chk("wr1_pwdata", pw, 32'hA5A5_0001);
    chk("wr1_pwrite", 32'(pwr), 32'h1);
    chk("wr1_lat", 32'(lat), 32'd3);
    chk("wr1_err", 32'(er), 32'h0);
    chk("wr1_rdata", rd, 32'h0);
    @(negedge FAB_CLK);
    chk("wr1_ready_pulse", 32'(MSSPREADY), 32'h0);

    // slot2 read with two wait states
    xfer(1'b0, 20'h00224, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("rd2_psel", 32'(ps), 32'h4);
    chk("rd2_lat", 32'(lat), 32'd5);
    chk("rd2_rdata", rd, 32'h1234_5678);
    chk("rd2_err", 32'(er), 32'h0);
    @(negedge FAB_CLK);
    chk("rd2_rdata_after", MSSPRDATA, 32'h0);

    // slave error forwarded with read data
    S_PSLVERR = 4'b0010;
    xfer(1'b0, 20'h00104, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("rd1err_lat", 32'(lat), 32'd3);
    chk("rd1err_err", 32'(er), 32'h1);
    chk("rd1err_rdata", rd, 32'hCAFE_0001);
    S_PSLVERR = 4'b0000;
    @(negedge FAB_CLK);

    // unmapped slot5
    xfer(1'b0, 20'h00500, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("unmap_lat", 32'(lat), 32'd1);
    chk("unmap_err", 32'(er), 32'h1);
    chk("unmap_rdata", rd, 32'h0);
    chk("unmap_psel", 32'(ps), 32'h0);
    @(negedge FAB_CLK);

    // upstream select dropped after setup: transfer still completes
    xfer(1'b0, 20'h00300, 32'h0, 1'b1, lat, rd, er, ps, pa, pw, pwr);
    chk("drop_lat", 32'(lat), 32'd3);
    chk("drop_rdata", rd, 32'hBEEF_0003);
    @(negedge FAB_CLK);

    // local register: TO_STAT initially 0, unknown offset reads 0
    xfer(1'b0, 20'h00708, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("tostat0_lat", 32'(lat), 32'd2);
    chk("tostat0_rdata", rd, 32'h0);
    @(negedge FAB_CLK);
    xfer(1'b0, 20'h0070C, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("locbad_rdata", rd, 32'h0);
    chk("locbad_err", 32'(er), 32'h0);
    @(negedge FAB_CLK);

    // slot0 never ready: timeout after 255 ACCESS cycles
    xfer(1'b0, 20'h00004, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("to_lat", 32'(lat), 32'd257);
    chk("to_err", 32'(er), 32'h1);
    chk("to_rdata", rd, 32'h0);
    @(negedge FAB_CLK);
    xfer(1'b0, 20'h00708, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("tostat_rdata", rd, 32'h8);
    @(negedge FAB_CLK);
    xfer(1'b1, 20'h00708, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    @(negedge FAB_CLK);
    xfer(1'b0, 20'h00708, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("tostat_clr", rd, 32'h0);
    @(negedge FAB_CLK);

    // interrupt mask / pending / FABINT
    xfer(1'b1, 20'h00704, 32'h8, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    @(negedge FAB_CLK);
    xfer(1'b0, 20'h00704, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("mask_rd", rd, 32'h8);
    @(negedge FAB_CLK);
    S_IRQ = 4'b1000;
    @(negedge FAB_CLK);
    S_IRQ = 4'b0000;
    chk("fabint_lag", 32'(FABINT), 32'h0);
    @(negedge FAB_CLK);
    chk("fabint_set", 32'(FABINT), 32'h1);
    xfer(1'b0, 20'h00700, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("pend_rd", rd, 32'h8);
    @(negedge FAB_CLK);
    xfer(1'b1, 20'h00700, 32'h8, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    @(negedge FAB_CLK);
    chk("fabint_w1c", 32'(FABINT), 32'h0);
    S_IRQ = 4'b1000;
    repeat (2) @(negedge FAB_CLK);
    chk("fabint_reset2", 32'(FABINT), 32'h1);
    xfer(1'b1, 20'h00700, 32'h8, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    @(negedge FAB_CLK);
    chk("fabint_setwins", 32'(FABINT), 32'h1);
    xfer(1'b0, 20'h00700, 32'h0, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("pend_setwins", rd, 32'h8);
    S_IRQ = 4'b0000;
    @(negedge FAB_CLK);

    // reset during ACCESS drops the transfer
    MSSPSEL = 1'b1; MSSPENABLE = 1'b0; MSSPWRITE = 1'b0; MSSPADDR = 20'h00000;
    @(negedge FAB_CLK);
    MSSPENABLE = 1'b1;
    @(negedge FAB_CLK);
    chk("rstacc_penable", 32'(S_PENABLE), 32'h1);
    FAB_RESET = 1'b1;
    @(negedge FAB_CLK);
    chk("rstacc_psel", 32'(S_PSEL), 32'h0);
    chk("rstacc_penable0", 32'(S_PENABLE), 32'h0);
    chk("rstacc_ready", 32'(MSSPREADY), 32'h0);
    FAB_RESET = 1'b0; MSSPSEL = 1'b0; MSSPENABLE = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    chk("rstacc_noresp", 32'(MSSPREADY), 32'h0);
    xfer(1'b1, 20'h00120, 32'h0000_00AA, 1'b0, lat, rd, er, ps, pa, pw, pwr);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_psel", 32'(ps), 32'h2);
    chk("post_rst_err", 32'(er), 32'h0);
    @(negedge FAB_CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
